// File: rtl/eth_phy_10g_rx_block_lock_mlane_pkg.sv
// Shared PCS receive constants and types for the block-lock engine.
package eth_phy_10g_pcs_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam int SH_WINDOW_DEF      = 64;
  localparam int SH_INVALID_MAX_DEF = 16;
  localparam int BITSLIP_HIGH_DEF   = 1;
  localparam int BITSLIP_LOW_DEF    = 8;

  typedef enum logic [1:0] {
    RESET_CNT = 2'd0,
    TEST_SH   = 2'd1,
    SLIP_HIGH = 2'd2,
    SLIP_LOW  = 2'd3
  } lock_state_e;

  // A sync header is legal only as a data or control marker.
  function automatic logic sh_is_valid(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_phy_10g_rx_block_lock_mlane_if.sv
// Header input / lock status bundle between gearbox, lock engine and PCS.
interface eth_phy_10g_rx_block_lock_mlane_if #(
  parameter int LANES     = 1,
  parameter int HDR_WIDTH = 2
);
  logic [LANES*HDR_WIDTH-1:0] serdes_rx_hdr;
  logic [LANES-1:0]           serdes_rx_hdr_valid;
  logic                       cfg_force_unlock;
  logic [LANES-1:0]           serdes_rx_bitslip;
  logic [LANES-1:0]           rx_block_lock;
  logic                       rx_block_lock_all;
  logic [LANES-1:0]           rx_lock_loss;

  modport master (
    output serdes_rx_hdr, serdes_rx_hdr_valid, cfg_force_unlock,
    input  serdes_rx_bitslip, rx_block_lock, rx_block_lock_all, rx_lock_loss
  );

  modport slave (
    input  serdes_rx_hdr, serdes_rx_hdr_valid, cfg_force_unlock,
    output serdes_rx_bitslip, rx_block_lock, rx_block_lock_all, rx_lock_loss
  );
endinterface

// File: rtl/eth_phy_10g_rx_block_lock_lane.sv
// Single-lane 64b/66b block-lock engine with bitslip pulse and settle timer.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// RESET_CNT | clear window counters, discard this cycle's header
// TEST_SH   | count qualified headers (hunting when unlocked, monitoring when locked)
// SLIP_HIGH | bitslip request active for BITSLIP_HIGH_CYCLES
// SLIP_LOW  | settle after the slip, headers ignored
module eth_phy_10g_rx_block_lock_lane
  import eth_phy_10g_pcs_pkg::*;
#(
  parameter int SH_WINDOW           = SH_WINDOW_DEF,
  parameter int SH_INVALID_MAX      = SH_INVALID_MAX_DEF,
  parameter int BITSLIP_HIGH_CYCLES = BITSLIP_HIGH_DEF,
  parameter int BITSLIP_LOW_CYCLES  = BITSLIP_LOW_DEF
) (
  input  logic       rx_clk,
  input  logic       rx_rst_n,
  input  logic [1:0] hdr,
  input  logic       hdr_valid,
  input  logic       force_unlock,
  output logic       bitslip,
  output logic       lock,
  output logic       lock_loss
);

  localparam int SH_CNT_W  = $clog2(SH_WINDOW + 1);
  localparam int INV_CNT_W = $clog2(SH_INVALID_MAX + 1);
  localparam int TMR_MAX   = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
                             BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);

  localparam logic [SH_CNT_W-1:0]  SH_LAST   = SH_CNT_W'(SH_WINDOW - 1);
  localparam logic [INV_CNT_W-1:0] INV_LAST  = INV_CNT_W'(SH_INVALID_MAX - 1);
  localparam logic [TMR_W-1:0]     TMR_HIGH  = TMR_W'(BITSLIP_HIGH_CYCLES - 1);
  localparam logic [TMR_W-1:0]     TMR_LOW   = TMR_W'(BITSLIP_LOW_CYCLES - 1);

  lock_state_e          state_q, state_d;
  logic [SH_CNT_W-1:0]  sh_cnt_q, sh_cnt_d;
  logic [INV_CNT_W-1:0] sh_invalid_cnt_q, sh_invalid_cnt_d;
  logic [TMR_W-1:0]     slip_tmr_q, slip_tmr_d;
  logic                 lock_q, lock_d;
  logic                 lock_loss_q, lock_loss_d;
  logic                 bitslip_q, bitslip_d;
  logic                 hdr_ok;

  // Next-state, window counters and slip timer; force_unlock overrides everything.
  always_comb begin
    state_d          = state_q;
    sh_cnt_d         = sh_cnt_q;
    sh_invalid_cnt_d = sh_invalid_cnt_q;
    slip_tmr_d       = slip_tmr_q;
    lock_d           = lock_q;
    lock_loss_d      = 1'b0;
    hdr_ok           = sh_is_valid(hdr);

    if (force_unlock) begin
      state_d          = RESET_CNT;
      sh_cnt_d         = '0;
      sh_invalid_cnt_d = '0;
      slip_tmr_d       = '0;
      lock_d           = 1'b0;
      lock_loss_d      = lock_q;
    end else begin
      case (state_q)
        RESET_CNT: begin
          sh_cnt_d         = '0;
          sh_invalid_cnt_d = '0;
          state_d          = TEST_SH;
        end
        TEST_SH: begin
          if (hdr_valid) begin
            if (!lock_q) begin
              if (!hdr_ok) begin
                state_d    = SLIP_HIGH;
                slip_tmr_d = TMR_HIGH;
              end else if (sh_cnt_q == SH_LAST) begin
                lock_d  = 1'b1;
                state_d = RESET_CNT;
              end else begin
                sh_cnt_d = sh_cnt_q + 1'b1;
              end
            end else begin
              // Invalid threshold takes priority over a window completing on the same header.
              if (!hdr_ok && (sh_invalid_cnt_q == INV_LAST)) begin
                lock_d      = 1'b0;
                lock_loss_d = 1'b1;
                state_d     = SLIP_HIGH;
                slip_tmr_d  = TMR_HIGH;
              end else if (sh_cnt_q == SH_LAST) begin
                state_d = RESET_CNT;
              end else begin
                sh_cnt_d = sh_cnt_q + 1'b1;
                if (!hdr_ok) sh_invalid_cnt_d = sh_invalid_cnt_q + 1'b1;
              end
            end
          end
        end
        SLIP_HIGH: begin
          if (slip_tmr_q == '0) begin
            if (BITSLIP_LOW_CYCLES == 0) begin
              state_d = RESET_CNT;
            end else begin
              state_d    = SLIP_LOW;
              slip_tmr_d = TMR_LOW;
            end
          end else begin
            slip_tmr_d = slip_tmr_q - 1'b1;
          end
        end
        SLIP_LOW: begin
          if (slip_tmr_q == '0) state_d = RESET_CNT;
          else                  slip_tmr_d = slip_tmr_q - 1'b1;
        end
        default: state_d = RESET_CNT;
      endcase
    end

    // The slip request follows the SLIP_HIGH state by one registered stage.
    bitslip_d = (state_q == SLIP_HIGH) && !force_unlock;
  end

  // State and registered outputs.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q          <= RESET_CNT;
      sh_cnt_q         <= '0;
      sh_invalid_cnt_q <= '0;
      slip_tmr_q       <= '0;
      lock_q           <= 1'b0;
      lock_loss_q      <= 1'b0;
      bitslip_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      sh_cnt_q         <= sh_cnt_d;
      sh_invalid_cnt_q <= sh_invalid_cnt_d;
      slip_tmr_q       <= slip_tmr_d;
      lock_q           <= lock_d;
      lock_loss_q      <= lock_loss_d;
      bitslip_q        <= bitslip_d;
    end
  end

  assign bitslip   = bitslip_q;
  assign lock      = lock_q;
  assign lock_loss = lock_loss_q;

endmodule

// File: rtl/eth_phy_10g_rx_block_lock_mlane.sv
// Multi-lane block lock: slices headers per lane and aggregates lock status.
module eth_phy_10g_rx_block_lock_mlane
  import eth_phy_10g_pcs_pkg::*;
#(
  parameter int LANES               = 1,
  parameter int HDR_WIDTH           = 2,
  parameter int SH_WINDOW           = SH_WINDOW_DEF,
  parameter int SH_INVALID_MAX      = SH_INVALID_MAX_DEF,
  parameter int BITSLIP_HIGH_CYCLES = BITSLIP_HIGH_DEF,
  parameter int BITSLIP_LOW_CYCLES  = BITSLIP_LOW_DEF
) (
  input  logic rx_clk,
  input  logic rx_rst_n,
  eth_phy_10g_rx_block_lock_mlane_if.slave rx_if
);

  logic [LANES-1:0] bitslip_w;
  logic [LANES-1:0] lock_w;
  logic [LANES-1:0] lock_loss_w;

  // One independent lock engine per lane.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    eth_phy_10g_rx_block_lock_lane #(
      .SH_WINDOW           (SH_WINDOW),
      .SH_INVALID_MAX      (SH_INVALID_MAX),
      .BITSLIP_HIGH_CYCLES (BITSLIP_HIGH_CYCLES),
      .BITSLIP_LOW_CYCLES  (BITSLIP_LOW_CYCLES)
    ) u_lane (
      .rx_clk       (rx_clk),
      .rx_rst_n     (rx_rst_n),
      .hdr          (rx_if.serdes_rx_hdr[k*HDR_WIDTH +: HDR_WIDTH]),
      .hdr_valid    (rx_if.serdes_rx_hdr_valid[k]),
      .force_unlock (rx_if.cfg_force_unlock),
      .bitslip      (bitslip_w[k]),
      .lock         (lock_w[k]),
      .lock_loss    (lock_loss_w[k])
    );
  end

  assign rx_if.serdes_rx_bitslip = bitslip_w;
  assign rx_if.rx_block_lock     = lock_w;
  assign rx_if.rx_lock_loss      = lock_loss_w;
  assign rx_if.rx_block_lock_all = &lock_w;

endmodule

// File: tb/tb_eth_phy_10g_rx_block_lock_mlane.sv
module tb_eth_phy_10g_rx_block_lock_mlane;

  localparam int LANES = 4;
  localparam int W     = 64;
  localparam int MAXI  = 16;
  localparam int SH    = 1;
  localparam int SL    = 8;

  logic rx_clk   = 1'b0;
  logic rx_rst_n = 1'b0;
  always #5 rx_clk = ~rx_clk;

  eth_phy_10g_rx_block_lock_mlane_if #(.LANES(LANES)) rx_if ();

  eth_phy_10g_rx_block_lock_mlane #(
    .LANES(LANES), .HDR_WIDTH(2), .SH_WINDOW(W), .SH_INVALID_MAX(MAXI),
    .BITSLIP_HIGH_CYCLES(SH), .BITSLIP_LOW_CYCLES(SL)
  ) dut (
    .rx_clk   (rx_clk),
    .rx_rst_n (rx_rst_n),
    .rx_if    (rx_if)
  );

  int checks = 0;
  int errors = 0;
  int n      = 0;

  // Reference model: per-lane window tallies, edge at which counting resumes,
  // and edge of the most recent slip decision.
  bit m_lock   [LANES];
  bit m_loss   [LANES];
  int m_hdrs   [LANES];
  int m_bad    [LANES];
  int m_resume [LANES];
  int m_slip   [LANES];
  logic [LANES-1:0] exp_lock, exp_bs, exp_loss;

  typedef struct {
    logic [7:0] hdr;
    logic [3:0] vld;
    bit         frc;
    int         cyc;
    logic [3:0] lock_exp;
  } seg_t;
  seg_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at edge %0d", name, act, exp, n);
    end
  endtask

  function automatic void model_reset();
    n = 0;
    for (int k = 0; k < LANES; k++) begin
      m_lock[k] = 0; m_loss[k] = 0; m_hdrs[k] = 0; m_bad[k] = 0;
      m_resume[k] = 2; m_slip[k] = -1000;
    end
    exp_lock = '0; exp_bs = '0; exp_loss = '0;
  endfunction

  task automatic model_edge(input logic [7:0] hdr, input logic [3:0] vld, input bit frc);
    n++;
    for (int k = 0; k < LANES; k++) begin
      logic [1:0] h;
      bit ok;
      h = hdr[2*k +: 2];
      ok = (h[1] != h[0]);
      m_loss[k] = 0;
      if (frc) begin
        m_loss[k] = m_lock[k]; m_lock[k] = 0; m_hdrs[k] = 0; m_bad[k] = 0;
        m_resume[k] = n + 2; m_slip[k] = -1000;
      end else if (n >= m_resume[k] && vld[k]) begin
        if (!m_lock[k]) begin
          if (ok) begin
            m_hdrs[k]++;
            if (m_hdrs[k] == W) begin
              m_lock[k] = 1; m_hdrs[k] = 0; m_resume[k] = n + 2;
            end
          end else begin
            m_slip[k] = n; m_hdrs[k] = 0; m_bad[k] = 0; m_resume[k] = n + SH + SL + 2;
          end
        end else begin
          m_hdrs[k]++;
          if (!ok) m_bad[k]++;
          if (m_bad[k] == MAXI) begin
            m_lock[k] = 0; m_loss[k] = 1;
            m_slip[k] = n; m_hdrs[k] = 0; m_bad[k] = 0; m_resume[k] = n + SH + SL + 2;
          end else if (m_hdrs[k] == W) begin
            m_hdrs[k] = 0; m_bad[k] = 0; m_resume[k] = n + 2;
          end
        end
      end
      exp_lock[k] = m_lock[k];
      exp_loss[k] = m_loss[k];
      exp_bs[k]   = (n >= m_slip[k] + 1) && (n <= m_slip[k] + SH);
    end
  endtask

  task automatic step(input logic [7:0] hdr, input logic [3:0] vld, input bit frc);
    @(negedge rx_clk);
    rx_if.serdes_rx_hdr       = hdr;
    rx_if.serdes_rx_hdr_valid = vld;
    rx_if.cfg_force_unlock    = frc;
    @(posedge rx_clk);
    model_edge(hdr, vld, frc);
    #1;
    check("bitslip",  32'(rx_if.serdes_rx_bitslip), 32'(exp_bs));
    check("lock",     32'(rx_if.rx_block_lock),     32'(exp_lock));
    check("lock_loss", 32'(rx_if.rx_lock_loss),     32'(exp_loss));
    check("lock_all", 32'(rx_if.rx_block_lock_all), 32'(&exp_lock));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_bitslip"}, 32'(rx_if.serdes_rx_bitslip), 32'h0);
    check({name, "_lock"},    32'(rx_if.rx_block_lock),     32'h0);
    check({name, "_loss"},    32'(rx_if.rx_lock_loss),      32'h0);
    check({name, "_all"},     32'(rx_if.rx_block_lock_all), 32'h0);
  endtask

  task automatic do_reset();
    rx_rst_n = 1'b0;
    rx_if.serdes_rx_hdr       = '0;
    rx_if.serdes_rx_hdr_valid = '0;
    rx_if.cfg_force_unlock    = 1'b0;
    repeat (2) @(posedge rx_clk);
    #3;
    check_all_zero("reset");
    @(posedge rx_clk);
    #2 rx_rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    int first_k;
    logic [7:0] hdr;
    logic [3:0] vld;
    int pden[LANES] = '{300, 60, 20, 4};

    // lanes packed {l3,l2,l1,l0}
    tbl[0] = '{8'h76, 4'hF, 1'b0, 64, 4'b0000};
    tbl[1] = '{8'h76, 4'hF, 1'b0,  1, 4'b1011};
    tbl[2] = '{8'h76, 4'hF, 1'b0, 10, 4'b1011};
    tbl[3] = '{8'h76, 4'hF, 1'b1,  1, 4'b0000};
    tbl[4] = '{8'h55, 4'hF, 1'b0, 64, 4'b0000};
    tbl[5] = '{8'h55, 4'hF, 1'b0,  1, 4'b1111};
    tbl[6] = '{8'hFF, 4'h0, 1'b0, 30, 4'b1111};
    tbl[7] = '{8'h00, 4'h1, 1'b0, 16, 4'b1110};
    tbl[8] = '{8'hAA, 4'hF, 1'b0,  3, 4'b1110};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      for (int c = 0; c < tbl[i].cyc; c++) step(tbl[i].hdr, tbl[i].vld, tbl[i].frc);
      check($sformatf("tbl%0d_lock", i), 32'(rx_if.rx_block_lock), 32'(tbl[i].lock_exp));
      check($sformatf("tbl%0d_all", i), 32'(rx_if.rx_block_lock_all), 32'(tbl[i].lock_exp == 4'hF));
    end

    // Lock, tolerate 12 errors in one window, then drop on the 16th consecutive invalid.
    do_reset();
    repeat (65) step(8'hAA, 4'hF, 1'b0);
    step(8'hAA, 4'hF, 1'b0);
    cnt = 0;
    for (int g = 0; g < 4; g++)
      for (int j = 0; j < 16; j++) begin
        step((j < 3) ? 8'hFF : 8'hAA, 4'hF, 1'b0);
        if (rx_if.rx_lock_loss != 0) cnt++;
      end
    check("err_window_loss", 32'(cnt), 32'd0);
    check("err_window_lock", 32'(rx_if.rx_block_lock), 32'hF);
    step(8'hAA, 4'hF, 1'b0);
    repeat (15) step(8'hFF, 4'hF, 1'b0);
    check("pre_drop_lock", 32'(rx_if.rx_block_lock), 32'hF);
    step(8'hFF, 4'hF, 1'b0);
    check("drop_lock", 32'(rx_if.rx_block_lock), 32'h0);
    check("drop_loss", 32'(rx_if.rx_lock_loss), 32'hF);
    check("drop_bs_same", 32'(rx_if.serdes_rx_bitslip), 32'h0);
    step(8'hAA, 4'hF, 1'b0);
    check("drop_bs_next", 32'(rx_if.serdes_rx_bitslip), 32'hF);
    step(8'hAA, 4'hF, 1'b0);
    check("drop_bs_end", 32'(rx_if.serdes_rx_bitslip), 32'h0);

    // Unlocked alternating valid/invalid: one slip per counted invalid.
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step((i % 2 == 0) ? 8'hAA : 8'hFF, 4'hF, 1'b0);
      if (rx_if.serdes_rx_bitslip[0]) cnt++;
    end
    check("alt_pulses", 32'(cnt), 32'd3);
    check("alt_lock", 32'(rx_if.rx_block_lock), 32'h0);

    // Qualifier toggling; invalid headers only on unqualified cycles.
    step(8'hAA, 4'hF, 1'b1);
    first_k = -1;
    for (int k = 1; k <= 140; k++) begin
      step((k % 2 == 1) ? 8'hAA : 8'hFF, (k % 2 == 1) ? 4'hF : 4'h0, 1'b0);
      if (first_k < 0 && rx_if.rx_block_lock[0]) first_k = k;
    end
    check("qual_lock_cycle", 32'(first_k), 32'd129);

    // Force during SLIP_HIGH of lane 2 cancels the pulse; relock in 65 cycles.
    step(8'hAA, 4'hF, 1'b1);
    step(8'hAA, 4'hF, 1'b0);
    step(8'hBA, 4'hF, 1'b0);
    step(8'hAA, 4'hF, 1'b1);
    check("force_slip_bs", 32'(rx_if.serdes_rx_bitslip), 32'h0);
    first_k = -1;
    for (int k = 1; k <= 80; k++) begin
      step(8'h55, 4'hF, 1'b0);
      if (first_k < 0 && rx_if.rx_block_lock == 4'hF) first_k = k;
    end
    check("force_relock", 32'(first_k), 32'd65);

    // Reset while lane 2 is mid-bitslip.
    repeat (17) step(8'hBA, 4'hF, 1'b0);
    check("pre_rst_bs", 32'(rx_if.serdes_rx_bitslip), 32'h4);
    #2 rx_rst_n = 1'b0;
    #1 check_all_zero("midrst");
    @(posedge rx_clk);
    #2 rx_rst_n = 1'b1;
    model_reset();
    first_k = -1;
    for (int k = 1; k <= 80; k++) begin
      step(8'h55, 4'hF, 1'b0);
      if (first_k < 0 && rx_if.rx_block_lock == 4'hF) first_k = k;
    end
    check("rst_relock", 32'(first_k), 32'd65);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < LANES; k++) begin
        if ($urandom_range(0, pden[k] - 1) == 0) hdr[2*k +: 2] = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
        else                                     hdr[2*k +: 2] = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
        vld[k] = ($urandom_range(0, 7) != 0);
      end
      step(hdr, vld, $urandom_range(0, 799) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
